pipe_hazard_ctrl: RTL
=====================

Name: pipe_hazard_ctrl

Overview:
Pipeline control unit for the 5-stage RV32 core. It generates the stall and flush (bubble) controls for the PC, IF/ID, ID/EX and EX/MEM registers. It covers three cases: load-use hazards, taken branch/jump redirects from EX, and the multi-cycle divider, which is sequenced with a start/done handshake. It sits beside the ID/EX register, taking decoded ID fields and registered EX fields, and drives the enables/clears of all pipeline registers.

Parameters:
MD_MAX_WAIT, 64, maximum cycles in MD_WAIT before the watchdog aborts; legal range 2..65535.
CNT_W, 16, width of the stall performance counter.

Ports:
clk  in  1  clock
rst  in  1  reset
id_rs1_addr  in  5  rs1 index of the instruction in ID
id_rs2_addr  in  5  rs2 index of the instruction in ID
id_rs1_used  in  1  ID instruction reads rs1
id_rs2_used  in  1  ID instruction reads rs2
ex_opcode  in  7  opcode held in ID/EX
ex_rd_we  in  1  EX instruction writes rd
ex_rd_addr  in  5  EX destination index
ex_is_div  in  1  EX holds DIV/DIVU/REM/REMU
ex_redirect  in  1  EX branch taken or JAL/JALR
md_done  in  1  divider result valid (one-cycle pulse)
pc_stall  out  1  hold PC
ifid_stall  out  1  hold IF/ID
ifid_flush  out  1  clear IF/ID to NOP
idex_stall  out  1  hold ID/EX
idex_flush  out  1  clear ID/EX to bubble
exmem_flush  out  1  clear EX/MEM to bubble
md_start  out  1  divider start pulse
md_busy  out  1  state is MD_WAIT
md_err  out  1  sticky watchdog timeout flag
stall_cnt  out  CNT_W  saturating count of cycles with pc_stall=1

Behaviour:
- Reset: rst and clk are synchronous, active-high. On reset the state goes to RUN, the wait counter to 0, md_err to 0 and stall_cnt to 0. While rst is high, all stalls and md_start are 0 and all three flushes are 1. A reset during MD_WAIT aborts the divide; md_start is not reissued.
- States: RUN and MD_WAIT. All control outputs are combinational from the state and the inputs; state, counters and md_err are registered.
- Load-use hazard, lu: ex_opcode==7'b0000011 and ex_rd_we and ex_rd_addr!=0 and ((id_rs1_used and id_rs1_addr==ex_rd_addr) or (id_rs2_used and id_rs2_addr==ex_rd_addr)).
- RUN priority: ex_redirect > ex_is_div > lu > none.
  - ex_redirect: ifid_flush=1, idex_flush=1, no stalls, stay in RUN.
  - ex_is_div: md_start=1, pc_stall=ifid_stall=idex_stall=1, exmem_flush=1; next state MD_WAIT, wait counter cleared.
  - lu: pc_stall=ifid_stall=1, idex_flush=1; stays exactly 1 cycle because the load leaves EX.
  - none: all controls 0.
- md_done in RUN is ignored. The divider never asserts done in the start cycle.
- MD_WAIT: md_busy=1. ex_redirect and lu are ignored.
  - md_done=0: pc_stall=ifid_stall=idex_stall=1, exmem_flush=1, wait counter +1.
  - md_done=1: all stalls and flushes are 0 that cycle, so the div result advances to MEM; next state RUN.
  - Counter reaches MD_MAX_WAIT-1 with md_done=0: that cycle behaves as md_done=1 (release). md_err is set and is sticky until rst; next state RUN.
- md_start is high only in a RUN cycle with ex_is_div, so exactly one pulse per divide. Back-to-back divides return to RUN for 1 cycle, then re-issue.
- stall_cnt: +1 on each cycle with pc_stall=1 and rst=0; saturates at all-ones.
- Invariant: stall and flush are never both 1 on the same register.

Test Plan:
- Load-use: LW x5 in EX (ex_opcode=0000011, ex_rd_addr=5, ex_rd_we=1), ID ADD with rs2=5 used -> pc_stall=ifid_stall=idex_flush=1 for exactly 1 cycle, stall_cnt=1. With ex_rd_addr=0 -> no stall.
- Redirect plus lu in the same cycle -> ifid_flush=idex_flush=1, pc_stall=0, stall_cnt unchanged.
- Divide: ex_is_div=1, md_done pulses 5 cycles after md_start -> md_start high 1 cycle; md_busy high 5 cycles; stalls high for 5 cycles total, then 0 in the md_done cycle; stall_cnt=5.
- Watchdog: MD_MAX_WAIT=8, md_done never asserted -> release after 8 stalled cycles (1 start + 7 wait), md_err=1 and held; rst clears it.
- Reset asserted mid-MD_WAIT -> next cycle state RUN, md_busy=0, all flushes 1 while rst high, no md_start after rst falls unless ex_is_div.
- Saturation: CNT_W=4, 20 stalled cycles -> stall_cnt=15.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard control for the 5-stage RV32 core.
// Produces stall/flush controls for load-use, EX redirects and the multi-cycle divider handshake.
module pipe_hazard_ctrl #(
    parameter int MD_MAX_WAIT = 64,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       id_rs1_addr,
    input  logic [4:0]       id_rs2_addr,
    input  logic             id_rs1_used,
    input  logic             id_rs2_used,
    input  logic [6:0]       ex_opcode,
    input  logic             ex_rd_we,
    input  logic [4:0]       ex_rd_addr,
    input  logic             ex_is_div,
    input  logic             ex_redirect,
    input  logic             md_done,
    output logic             pc_stall,
    output logic             ifid_stall,
    output logic             ifid_flush,
    output logic             idex_stall,
    output logic             idex_flush,
    output logic             exmem_flush,
    output logic             md_start,
    output logic             md_busy,
    output logic             md_err,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam int WAIT_W = $clog2(MD_MAX_WAIT);

    localparam logic [0:0] ST_RUN     = 1'b0;
    localparam logic [0:0] ST_MD_WAIT = 1'b1;

    localparam logic [6:0] OP_LOAD = 7'b0000011;

    logic [0:0]        state;
    logic [0:0]        state_nxt;
    logic [WAIT_W-1:0] wait_cnt;
    logic [WAIT_W-1:0] wait_cnt_nxt;
    logic              set_err;
    logic              load_use;
    logic              wd_expire;

    assign load_use = (ex_opcode == OP_LOAD) && ex_rd_we && (ex_rd_addr != 5'd0) &&
                      ((id_rs1_used && (id_rs1_addr == ex_rd_addr)) ||
                       (id_rs2_used && (id_rs2_addr == ex_rd_addr)));

    // The watchdog release happens in the cycle the counter sits at its last value.
    assign wd_expire = !md_done && (wait_cnt == WAIT_W'(MD_MAX_WAIT - 1));

    assign md_busy = (state == ST_MD_WAIT);

    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        pc_stall     = 1'b0;
        ifid_stall   = 1'b0;
        ifid_flush   = 1'b0;
        idex_stall   = 1'b0;
        idex_flush   = 1'b0;
        exmem_flush  = 1'b0;
        md_start     = 1'b0;
        state_nxt    = state;
        wait_cnt_nxt = wait_cnt;
        set_err      = 1'b0;

        if (rst) begin
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
            exmem_flush = 1'b1;
        end else begin
            case (state)
                ST_RUN: begin
                    if (ex_redirect) begin
                        ifid_flush = 1'b1;
                        idex_flush = 1'b1;
                    end else if (ex_is_div) begin
                        md_start     = 1'b1;
                        pc_stall     = 1'b1;
                        ifid_stall   = 1'b1;
                        idex_stall   = 1'b1;
                        exmem_flush  = 1'b1;
                        state_nxt    = ST_MD_WAIT;
                        wait_cnt_nxt = '0;
                    end else if (load_use) begin
                        pc_stall   = 1'b1;
                        ifid_stall = 1'b1;
                        idex_flush = 1'b1;
                    end
                end
                ST_MD_WAIT: begin
                    // Release (done or watchdog) lets the divide result move on to MEM.
                    if (md_done || wd_expire) begin
                        state_nxt = ST_RUN;
                        set_err   = wd_expire;
                    end else begin
                        pc_stall     = 1'b1;
                        ifid_stall   = 1'b1;
                        idex_stall   = 1'b1;
                        exmem_flush  = 1'b1;
                        wait_cnt_nxt = wait_cnt + WAIT_W'(1);
                    end
                end
                default: state_nxt = ST_RUN;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: registered state uses non-blocking assignments so all flops update together.
        if (rst) begin
            state     <= ST_RUN;
            wait_cnt  <= '0;
            md_err    <= 1'b0;
            stall_cnt <= '0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_cnt_nxt;
            if (set_err) begin
                md_err <= 1'b1;
            end
            if (pc_stall && (stall_cnt != {CNT_W{1'b1}})) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
        end
    end

endmodule
